mips_fetch_stage: RTL and testbench

Instruction-fetch stage that feeds the 32-bit `INST` word into the MIPS datapath top level, replacing the hard-wired instruction stimulus.
- Holds the program counter and issues word reads to a synchronous instruction memory with one-cycle read latency.
- Buffers returned words with their PCs in a 2-entry queue.
- Presents instructions downstream over a valid/ready handshake.
- Supports a redirect (branch/jump) input that flushes all buffered and in-flight fetches.

---
 rtl/mips_pkg.sv | 11 +
 rtl/mips_fetch_stage_if.sv | 21 ++
 rtl/fetch_buf.sv | 37 +++
 rtl/mips_fetch_stage.sv | 53 +++++
 tb/tb_mips_fetch_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS instruction-fetch path
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
  localparam logic [WORD_W-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;
  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/mips_fetch_stage_if.sv
// mips_fetch_stage_if: instruction-memory, redirect and downstream handshake bundle
interface mips_fetch_stage_if #(parameter int IMEM_AW = 10);
  import mips_pkg::*;
  logic imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [WORD_W-1:0] imem_rdata;
  logic redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] INST;
  logic [WORD_W-1:0] inst_pc;
  logic inst_valid;
  logic inst_ready;
  modport master (
    output imem_en, imem_addr, INST, inst_pc, inst_valid,
    input imem_rdata, redirect, redirect_pc, inst_ready
  );
  modport slave (
    input imem_en, imem_addr, INST, inst_pc, inst_valid,
    output imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry registered queue of {inst, pc}; head is always entry 0
module fetch_buf import mips_pkg::*; (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);
  fetch_entry_t r_q0, r_q1;
  logic [1:0] r_count;
  logic [1:0] w_slot;
  logic w_wr0, w_wr1;
  always_comb begin
    w_slot = r_count - {1'b0, i_pop};
    w_wr0 = i_push && w_slot == 2'd0;
    w_wr1 = i_push && w_slot == 2'd1;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_q0 <= '{inst: NOP_INST, pc: '0};
      r_q1 <= '{inst: NOP_INST, pc: '0};
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      assert (!(i_push && !i_pop && r_count == 2'd2));
      r_q0 <= w_wr0 ? i_push_data : (i_pop ? r_q1 : r_q0);
      r_q1 <= w_wr1 ? i_push_data : r_q1;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_head = r_q0;
  assign o_count = r_count;
endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: PC register and issue control feeding a 2-entry instruction queue
module mips_fetch_stage import mips_pkg::*; #(
  parameter logic [WORD_W-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int IMEM_AW = 10
) (
  input logic CLK,
  input logic RST,
  mips_fetch_stage_if.master bus
);
  logic [WORD_W-1:0] r_fetch_pc, r_req_pc;
  logic r_inflight;
  logic [1:0] w_count;
  fetch_entry_t w_head, w_push_data;
  logic w_pop, w_issue;
  logic [2:0] w_occ;
  logic [WORD_W-1:0] w_pc;
  always_comb begin
    w_pop = (w_count != 2'd0) & bus.inst_ready;
    // occupancy the queue will hold once this cycle's pop and pending response settle
    w_occ = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    w_issue = RST & (bus.redirect | (w_occ < 3'd2));
    w_pc = bus.redirect ? {bus.redirect_pc[WORD_W-1:2], 2'b00} : r_fetch_pc;
    w_push_data = '{inst: bus.imem_rdata, pc: r_req_pc};
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_fetch_pc <= PC_RESET;
      r_req_pc <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= w_pc;
        r_fetch_pc <= w_pc + PC_STEP;
      end
    end
  end
  fetch_buf u_buf (
    .CLK(CLK),
    .RST(RST),
    .i_push(r_inflight & ~bus.redirect),
    .i_push_data(w_push_data),
    .i_pop(w_pop),
    .i_flush(bus.redirect),
    .o_head(w_head),
    .o_count(w_count)
  );
  assign bus.imem_en = w_issue;
  assign bus.imem_addr = RST ? w_pc[IMEM_AW+1:2] : PC_RESET[IMEM_AW+1:2];
  assign bus.INST = w_head.inst;
  assign bus.inst_pc = w_head.pc;
  assign bus.inst_valid = w_count != 2'd0;
endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: directed scenarios plus random stimulus checked every cycle against a queue model
module tb_mips_fetch_stage;
  import mips_pkg::*;
  localparam int AW = 10;
  localparam logic [31:0] PCR = 32'h0000_0000;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  mips_fetch_stage_if #(.IMEM_AW(AW)) bus ();
  mips_fetch_stage #(.PC_RESET(PCR), .IMEM_AW(AW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  // synchronous memory: word i holds 32'h1000_0000 + i
  always @(posedge CLK) if (bus.imem_en) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
  function automatic logic [31:0] mem_word(logic [31:0] pc);
    return 32'h1000_0000 + {22'b0, pc[AW+1:2]};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: queue of pending instructions, one outstanding request slot
  fetch_entry_t m_q[$];
  logic [31:0] m_fetch = PCR;
  logic [31:0] m_req = '0;
  bit m_inf = 1'b0;
  bit m_clean = 1'b1;
  always @(negedge CLK) begin
    bit pop, exp_en;
    logic [31:0] exp_pc;
    pop = m_q.size() != 0 && bus.inst_ready;
    if (!RST) begin
      exp_en = 1'b0;
      exp_pc = PCR;
    end else if (bus.redirect) begin
      exp_en = 1'b1;
      exp_pc = bus.redirect_pc;
    end else begin
      exp_en = (m_q.size() + int'(m_inf) - int'(pop)) < 2;
      exp_pc = m_fetch;
    end
    chk("imem_en", 32'(bus.imem_en), 32'(exp_en));
    chk("imem_addr", 32'(bus.imem_addr), 32'(exp_pc[AW+1:2]));
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("INST", bus.INST, m_q[0].inst);
      chk("inst_pc", bus.inst_pc, m_q[0].pc);
    end else if (m_clean) begin
      chk("INST_after_reset", bus.INST, 32'h0);
      chk("inst_pc_after_reset", bus.inst_pc, 32'h0);
    end
    if (!RST) begin
      m_q.delete();
      m_inf = 1'b0;
      m_fetch = PCR;
      m_clean = 1'b1;
    end else if (bus.redirect) begin
      m_q.delete();
      m_req = {bus.redirect_pc[31:2], 2'b00};
      m_fetch = m_req + 32'd4;
      m_inf = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_inf) begin
        m_q.push_back('{inst: mem_word(m_req), pc: m_req});
        m_clean = 1'b0;
      end
      if (exp_en) begin
        m_req = m_fetch;
        m_fetch = m_fetch + 32'd4;
        m_inf = 1'b1;
      end else m_inf = 1'b0;
    end
  end
  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask
  task automatic at_neg;
    @(negedge CLK);
  endtask
  initial begin
    logic [31:0] held;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b1;
    RST = 1'b0;
    repeat (3) nxt;
    at_neg;
    chk("rst_en", 32'(bus.imem_en), 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.INST, 32'h0);
    nxt; RST = 1'b1;
    at_neg;
    chk("c0_en", 32'(bus.imem_en), 32'h1);
    chk("c0_addr", 32'(bus.imem_addr), 32'h0);
    chk("c0_valid", 32'(bus.inst_valid), 32'h0);
    nxt; at_neg;
    chk("c1_valid", 32'(bus.inst_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      nxt; at_neg;
      chk("stream_valid", 32'(bus.inst_valid), 32'h1);
      chk("stream_inst", bus.INST, 32'h1000_0000 + 32'(i));
      chk("stream_pc", bus.inst_pc, 32'(4 * i));
    end
    nxt; bus.inst_ready = 1'b0;
    at_neg;
    held = bus.INST;
    chk("bp_head", held, 32'h1000_0003);
    for (int i = 1; i < 5; i++) begin
      nxt; at_neg;
      chk("bp_en_low", 32'(bus.imem_en), 32'h0);
      chk("bp_inst_hold", bus.INST, held);
    end
    nxt; bus.inst_ready = 1'b1;
    at_neg;
    chk("bp_release_inst", bus.INST, 32'h1000_0003);
    chk("bp_release_en", 32'(bus.imem_en), 32'h1);
    nxt; at_neg;
    chk("bp_next_inst", bus.INST, 32'h1000_0004);
    chk("bp_next_pc", bus.inst_pc, 32'h10);
    nxt; bus.inst_ready = 1'b0;
    nxt; nxt;
    nxt; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    at_neg;
    chk("rd_addr", 32'(bus.imem_addr), 32'h40);
    chk("rd_en", 32'(bus.imem_en), 32'h1);
    chk("rd_two_queued", 32'(bus.inst_valid), 32'h1);
    nxt; bus.redirect = 1'b0; bus.inst_ready = 1'b1;
    at_neg;
    chk("rd_t1_valid", 32'(bus.inst_valid), 32'h0);
    nxt; at_neg;
    chk("rd_t2_valid", 32'(bus.inst_valid), 32'h1);
    chk("rd_t2_pc", bus.inst_pc, 32'h100);
    chk("rd_t2_inst", bus.INST, 32'h1000_0040);
    nxt; bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    nxt; bus.redirect_pc = 32'h300;
    nxt; bus.redirect = 1'b0;
    at_neg;
    chk("b2b_t2_valid", 32'(bus.inst_valid), 32'h0);
    nxt; at_neg;
    chk("b2b_t3_valid", 32'(bus.inst_valid), 32'h1);
    chk("b2b_t3_pc", bus.inst_pc, 32'h300);
    nxt; bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    nxt; bus.redirect = 1'b0;
    nxt; at_neg;
    chk("wrap_pc0", bus.inst_pc, 32'hFFFF_FFF8);
    chk("wrap_inst0", bus.INST, 32'h1000_03FE);
    nxt; at_neg;
    chk("wrap_pc1", bus.inst_pc, 32'hFFFF_FFFC);
    nxt; at_neg;
    chk("wrap_pc2", bus.inst_pc, 32'h0000_0000);
    chk("wrap_inst2", bus.INST, 32'h1000_0000);
    nxt; nxt; RST = 1'b0;
    at_neg;
    chk("mrst_en", 32'(bus.imem_en), 32'h0);
    nxt; RST = 1'b1;
    at_neg;
    chk("mrst_valid", 32'(bus.inst_valid), 32'h0);
    chk("mrst_inst", bus.INST, 32'h0);
    chk("mrst_pc", bus.inst_pc, 32'h0);
    chk("mrst_en_c0", 32'(bus.imem_en), 32'h1);
    nxt; at_neg;
    chk("mrst_c1_valid", 32'(bus.inst_valid), 32'h0);
    nxt; at_neg;
    chk("mrst_c2_valid", 32'(bus.inst_valid), 32'h1);
    chk("mrst_c2_pc", bus.inst_pc, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      nxt;
      bus.inst_ready = $urandom_range(0, 3) != 0;
      bus.redirect = $urandom_range(0, 19) == 0;
      bus.redirect_pc = $urandom;
      RST = $urandom_range(0, 99) != 0;
    end
    nxt;
    RST = 1'b1;
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (6) nxt;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
